uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `uart_tx` transmitter among `NUM_REQ` byte producers. It latches the winning requester's byte and drives `tx_start`/`din` into `uart_tx`. It tracks `tx_busy`/`tx_done` until the frame completes, then returns a completion pulse to the owner. It sits between the requesters and `uart_tx` (with its `uart_baudgen`), and is the only block allowed to drive `uart_tx` inputs.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `data_wd`, 8: frame data width; must match `uart_tx`.
- `START_TO`, 65535: cycles to wait for `tx_busy` after raising `tx_start` before abort.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester send request; level, may be held.
- `req_data`  in  NUM_REQ*data_wd  requester i byte at `[i*data_wd +: data_wd]`.
- `ack`  out  NUM_REQ  one-hot, 1-cycle pulse: byte of requester i captured.
- `done`  out  NUM_REQ  one-hot, 1-cycle pulse: frame of requester i finished (`tx_done` seen).
- `owner`  out  NUM_REQ  one-hot current grant; 0 when idle.
- `tx_start`  out  1  to `uart_tx`.
- `din`  out  data_wd  to `uart_tx`; stable for the whole owned period.
- `tx_busy`  in  1  from `uart_tx`.
- `tx_done`  in  1  from `uart_tx`.
- `arb_busy`  out  1  high in any state other than IDLE.
- `err_timeout`  out  1  1-cycle pulse on START timeout.

## Operation
- States: IDLE, START, WAIT_DONE, RELEASE. All outputs registered.
- IDLE: when `req != 0`, the winner is the first set `req` bit searched from `ptr` upward with wrap (`ptr`, `ptr+1`, …, `NUM_REQ-1`, 0, …). Latch the winner's `req_data` into `din`. Set `owner`, pulse `ack` and raise `tx_start`. Go to START.
- START: hold `tx_start`=1 until `tx_busy`=1, then drop `tx_start` and go to WAIT_DONE. `tx_start` is level-held because `uart_tx` samples it relative to tick.
- START timeout: if `START_TO` cycles elapse with `tx_busy`=0, drop `tx_start`, pulse `err_timeout`, clear `owner`, issue no `done`, advance `ptr` past the owner, and go to IDLE.
- WAIT_DONE: `din` held. On `tx_done`=1, pulse `done[owner]`, set `ptr` = owner index + 1 (mod `NUM_REQ`), clear `owner`, and go to RELEASE.
- RELEASE: one cycle that guarantees `tx_start`=0 is observed between frames. Then go to IDLE.
- `req` changes after `ack` are ignored until the next IDLE arbitration. A requester still holding `req` is re-arbitrated at lowest priority.
- `req_data` of non-winners is never sampled.
- Timeout counter is 16-bit. It clears on entering START and saturates at `START_TO`.
- `ptr` is `$clog2(NUM_REQ)` bits and wraps modulo `NUM_REQ`.

## Timing
- Reset (`rst`=1 at a rising edge): state IDLE, `ptr`=0, and all outputs 0 (`ack`, `done`, `owner`, `tx_start`, `din`, `arb_busy`, `err_timeout`).
- `rst` mid-frame aborts immediately: `tx_start`=0, no `done` pulse. The system resets `uart_tx` on the same `rst`.
- `req` seen high at edge N in IDLE: `ack`, `owner`, `tx_start` and `arb_busy` are high after edge N+1's update (1-cycle latency).
- `tx_busy` high at edge M: `tx_start` is low from M+1.
- `tx_done` high at edge K: `done` pulses at K+1, RELEASE at K+1, IDLE at K+2.
- Earliest next `ack` is K+3, so the minimum idle gap between frames is 2 cycles beyond `uart_tx` DONE.
- `tx_done` seen while in START or IDLE is ignored.
- `tx_busy` and `tx_done` are assumed synchronous to `clk`; no synchronizers.

## Test plan
- Reset: drive random `req` during `rst`=1 for 10 cycles → every output 0, no `ack`. After release with `req`=0 → `arb_busy` stays 0.
- Single requester: `req`=4'b0100, byte 0xA5, `uart_tx` 9600 baud / 50 MHz / odd parity → one `ack[2]`. Serial line carries start, 0xA5 LSB-first, parity 1, stop. `done[2]` occurs exactly one cycle after `tx_done`.
- Round-robin fairness: all four `req` held with bytes 0x11/0x22/0x33/0x44 for 8 frames → grant order 0,1,2,3,0,1,2,3. Bytes on the line match. Exactly 2 `done` per requester.
- Late arrival: `req[3]` rises while requester 1 is in WAIT_DONE, `req[0]` is held, and `ptr` is 2 after this frame → `req[3]` wins next, then 0.
- Timeout: `tx_busy` tied 0, `START_TO`=100, `req[1]` → `err_timeout` pulses 100 cycles after `tx_start` rises, `tx_start` drops, no `done`. Next grant goes to requester 2 if it is requesting.
- Mid-frame reset: assert `rst` during DATA bits of a 0x00 frame → `tx_start`=0, `owner`=0, no `done`. After release, a new 0xFF request transmits correctly with `ptr` restarted at 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx among NUM_REQ byte producers.
// Latches the winner's byte, sequences tx_start/tx_busy/tx_done and reports completion.
module uart_tx_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int data_wd  = 8,
   parameter int START_TO = 65535
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*data_wd-1:0] req_data,
   output logic [NUM_REQ-1:0]         ack,
   output logic [NUM_REQ-1:0]         done,
   output logic [NUM_REQ-1:0]         owner,
   output logic                       tx_start,
   output logic [data_wd-1:0]         din,
   input  logic                       tx_busy,
   input  logic                       tx_done,
   output logic                       arb_busy,
   output logic                       err_timeout
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [15:0] TO_LIMIT = 16'(START_TO);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_DONE = 2'd2,
      RELEASE   = 2'd3
   } state_t;

   state_t                state_r;
   logic [PTR_W-1:0]      ptr_r;
   logic [PTR_W-1:0]      own_idx_r;
   logic [15:0]           cnt_r;
   logic [NUM_REQ-1:0]    ack_r;
   logic [NUM_REQ-1:0]    done_r;
   logic [NUM_REQ-1:0]    owner_r;
   logic                  tx_start_r;
   logic [data_wd-1:0]    din_r;
   logic                  arb_busy_r;
   logic                  err_r;

   logic [PTR_W:0]        win_s;
   logic                  win_found_s;
   logic [PTR_W-1:0]      win_idx_s;
   logic [NUM_REQ-1:0]    win_onehot_s;
   logic                  to_hit_s;

   // First set request searching upward from p with wrap; returns {found, index}.
   function automatic logic [PTR_W:0] find_winner(input logic [NUM_REQ-1:0] r,
                                                  input logic [PTR_W-1:0]   p);
      logic             found;
      logic [PTR_W-1:0] idx;
      int               pos;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = int'(p) + k;
         if (pos >= NUM_REQ) pos = pos - NUM_REQ;
         if (!found && r[PTR_W'(pos)]) begin
            found = 1'b1;
            idx   = PTR_W'(pos);
         end
      end
      return {found, idx};
   endfunction

   function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] i);
      return (int'(i) == NUM_REQ - 1) ? '0 : i + PTR_W'(1);
   endfunction

   // Arbitration candidate and START timeout detection
   always_comb begin
      win_s        = find_winner(req, ptr_r);
      win_found_s  = win_s[PTR_W];
      win_idx_s    = win_s[PTR_W-1:0];
      win_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
      to_hit_s     = ({1'b0, cnt_r} + 17'd1) >= {1'b0, TO_LIMIT};
   end

   // Sequencer FSM with all outputs registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         ptr_r      <= '0;
         own_idx_r  <= '0;
         cnt_r      <= 16'd0;
         ack_r      <= '0;
         done_r     <= '0;
         owner_r    <= '0;
         tx_start_r <= 1'b0;
         din_r      <= '0;
         arb_busy_r <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         ack_r  <= '0;
         done_r <= '0;
         err_r  <= 1'b0;
         case (state_r)
            IDLE: begin
               if (win_found_s) begin
                  own_idx_r  <= win_idx_s;
                  owner_r    <= win_onehot_s;
                  ack_r      <= win_onehot_s;
                  din_r      <= req_data[win_idx_s*data_wd +: data_wd];
                  tx_start_r <= 1'b1;
                  cnt_r      <= 16'd0;
                  arb_busy_r <= 1'b1;
                  state_r    <= START;
               end else begin
                  arb_busy_r <= 1'b0;
               end
            end
            START: begin
               if (tx_busy) begin
                  tx_start_r <= 1'b0;
                  state_r    <= WAIT_DONE;
               end else if (to_hit_s) begin
                  // Give up on this owner and let the next requester go first
                  tx_start_r <= 1'b0;
                  err_r      <= 1'b1;
                  owner_r    <= '0;
                  ptr_r      <= ptr_after(own_idx_r);
                  arb_busy_r <= 1'b0;
                  state_r    <= IDLE;
               end else begin
                  cnt_r <= (cnt_r == TO_LIMIT) ? cnt_r : cnt_r + 16'd1;
               end
            end
            WAIT_DONE: begin
               if (tx_done) begin
                  done_r  <= owner_r;
                  ptr_r   <= ptr_after(own_idx_r);
                  owner_r <= '0;
                  state_r <= RELEASE;
               end else begin
                  state_r <= WAIT_DONE;
               end
            end
            RELEASE: begin
               arb_busy_r <= 1'b0;
               state_r    <= IDLE;
            end
            default: begin
               tx_start_r <= 1'b0;
               owner_r    <= '0;
               arb_busy_r <= 1'b0;
               state_r    <= IDLE;
            end
         endcase
      end
   end

   assign ack         = ack_r;
   assign done        = done_r;
   assign owner       = owner_r;
   assign tx_start    = tx_start_r;
   assign din         = din_r;
   assign arb_busy    = arb_busy_r;
   assign err_timeout = err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; the bench itself plays the uart_tx
// handshake (tx_busy/tx_done) and checks grants, bytes and pulses.
module tb_uart_tx_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  ack;
   logic [3:0]  done;
   logic [3:0]  owner;
   logic        tx_start;
   logic [7:0]  din;
   logic        tx_busy;
   logic        tx_done;
   logic        arb_busy;
   logic        err_timeout;

   int checks;
   int errors;

   uart_tx_arbiter #(.NUM_REQ(4), .data_wd(8), .START_TO(100)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data),
      .ack(ack), .done(done), .owner(owner), .tx_start(tx_start), .din(din),
      .tx_busy(tx_busy), .tx_done(tx_done), .arb_busy(arb_busy),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      tx_busy = 1'b0;
      tx_done = 1'b0;
      req     = 4'b0000;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   // Acts as uart_tx for one frame: returns owner/din/ack at grant and done after tx_done.
   task automatic serve_frame(input logic [3:0] clr, input logic [3:0] mid_set,
                              output logic [3:0] own, output logic [7:0] d,
                              output logic [3:0] a, output logic [3:0] dn);
      int i;
      i = 0;
      while (!tx_start && i < 50) begin
         tick();
         i++;
      end
      own = 4'b0000; d = 8'h00; a = 4'b0000; dn = 4'b0000;
      if (!tx_start) begin
         checks++; errors++;
         $display("FAIL frame_start: tx_start=%0b required 1 within 50 cycles", tx_start);
      end else begin
         own = owner;
         d   = din;
         a   = ack;
         req = req & ~clr;
         tick();
         tick();
         tx_busy = 1'b1;
         tick();
         checks++;
         if (tx_start !== 1'b0) begin
            errors++;
            $display("FAIL start_drop: tx_start=%0b required 0", tx_start);
         end
         req = req | mid_set;
         repeat (4) tick();
         tx_busy = 1'b0;
         tx_done = 1'b1;
         tick();
         dn      = done;
         tx_done = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         req      = 4'($urandom);
         req_data = $urandom;
         tick();
         checks++;
         if ({ack, done, owner, tx_start, din, arb_busy, err_timeout} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b done=%b owner=%b tx_start=%b din=%h arb_busy=%b err=%b required all 0",
                     ack, done, owner, tx_start, din, arb_busy, err_timeout);
         end
      end
      req = 4'b0000;
      rst = 1'b0;
      repeat (5) tick();
      checks++;
      if (arb_busy !== 1'b0 || ack !== 4'b0000) begin
         errors++;
         $display("FAIL reset_idle: arb_busy=%b ack=%b required 0 and 0000", arb_busy, ack);
      end
   endtask

   task automatic test_single();
      logic [3:0] own, a, dn;
      logic [7:0] d;
      req_data = 32'h3C_A5_5A_C3;
      req      = 4'b0100;
      serve_frame(4'b0100, 4'b0000, own, d, a, dn);
      checks++;
      if (own !== 4'b0100 || a !== 4'b0100 || d !== 8'hA5) begin
         errors++;
         $display("FAIL single_grant: owner=%b ack=%b din=%h required 0100 0100 a5", own, a, d);
      end
      checks++;
      if (dn !== 4'b0100) begin
         errors++;
         $display("FAIL single_done: done=%b required 0100", dn);
      end
      checks++;
      if (owner !== 4'b0000 || arb_busy !== 1'b1) begin
         errors++;
         $display("FAIL single_release: owner=%b arb_busy=%b required 0000 1", owner, arb_busy);
      end
      tick();
      checks++;
      if (done !== 4'b0000 || arb_busy !== 1'b0 || ack !== 4'b0000) begin
         errors++;
         $display("FAIL single_idle: done=%b arb_busy=%b ack=%b required 0000 0 0000", done, arb_busy, ack);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] own, a, dn;
      logic [7:0] d;
      logic [7:0] bytes [4];
      int dcnt [4];
      bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
      for (int i = 0; i < 4; i++) dcnt[i] = 0;
      do_reset();
      req_data = 32'h44_33_22_11;
      req      = 4'b1111;
      for (int f = 0; f < 8; f++) begin
         serve_frame(4'b0000, 4'b0000, own, d, a, dn);
         checks++;
         if (own !== (4'b0001 << (f % 4)) || d !== bytes[f % 4]) begin
            errors++;
            $display("FAIL rr_grant_%0d: owner=%b din=%h required %b %h",
                     f, own, d, 4'b0001 << (f % 4), bytes[f % 4]);
         end
         for (int i = 0; i < 4; i++) if (dn[i]) dcnt[i]++;
      end
      req = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (dcnt[i] != 2) begin
            errors++;
            $display("FAIL rr_done_count_%0d: count=%0d required 2", i, dcnt[i]);
         end
      end
      repeat (3) tick();
   endtask

   task automatic test_late_arrival();
      logic [3:0] own, a, dn;
      logic [7:0] d;
      do_reset();
      req_data = 32'hD4_C3_B2_A1;
      req      = 4'b0001;
      serve_frame(4'b0001, 4'b0000, own, d, a, dn);
      req = 4'b0011;
      serve_frame(4'b0010, 4'b1000, own, d, a, dn);
      checks++;
      if (own !== 4'b0010 || dn !== 4'b0010 || d !== 8'hB2) begin
         errors++;
         $display("FAIL late_first: owner=%b done=%b din=%h required 0010 0010 b2", own, dn, d);
      end
      serve_frame(4'b1000, 4'b0000, own, d, a, dn);
      checks++;
      if (own !== 4'b1000 || d !== 8'hD4) begin
         errors++;
         $display("FAIL late_winner: owner=%b din=%h required 1000 d4", own, d);
      end
      serve_frame(4'b0001, 4'b0000, own, d, a, dn);
      checks++;
      if (own !== 4'b0001 || d !== 8'hA1) begin
         errors++;
         $display("FAIL late_then_zero: owner=%b din=%h required 0001 a1", own, d);
      end
      repeat (3) tick();
   endtask

   task automatic test_timeout();
      logic [3:0] own, a, dn;
      logic [7:0] d;
      int n;
      logic saw_done;
      do_reset();
      req_data = 32'h00_3C_77_00;
      req      = 4'b0010;
      n = 0;
      while (!tx_start && n < 20) begin
         tick();
         n++;
      end
      n = 0;
      saw_done = 1'b0;
      while (!err_timeout && n < 200) begin
         tick();
         n++;
         if (done !== 4'b0000) saw_done = 1'b1;
      end
      checks++;
      if (n != 100) begin
         errors++;
         $display("FAIL timeout_latency: cycles=%0d required 100", n);
      end
      checks++;
      if (tx_start !== 1'b0 || owner !== 4'b0000 || arb_busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_state: tx_start=%b owner=%b arb_busy=%b required 0 0000 0", tx_start, owner, arb_busy);
      end
      checks++;
      if (saw_done) begin
         errors++;
         $display("FAIL timeout_no_done: done pulsed=1 required 0");
      end
      req = 4'b0110;
      serve_frame(4'b0110, 4'b0000, own, d, a, dn);
      checks++;
      if (own !== 4'b0100 || d !== 8'h3C) begin
         errors++;
         $display("FAIL timeout_next: owner=%b din=%h required 0100 3c", own, d);
      end
      repeat (3) tick();
   endtask

   task automatic test_mid_reset();
      logic [3:0] own, a, dn;
      logic [7:0] d;
      int n;
      do_reset();
      req_data = 32'h81_00_00_00;
      req      = 4'b0001;
      n = 0;
      while (!tx_start && n < 20) begin
         tick();
         n++;
      end
      req = 4'b0000;
      tick();
      tx_busy = 1'b1;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      checks++;
      if (tx_start !== 1'b0 || owner !== 4'b0000 || done !== 4'b0000 || arb_busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset_abort: tx_start=%b owner=%b done=%b arb_busy=%b required 0 0000 0000 0",
                  tx_start, owner, done, arb_busy);
      end
      tx_busy = 1'b0;
      tick();
      rst = 1'b0;
      req_data = 32'h81_00_00_FF;
      req      = 4'b1001;
      serve_frame(4'b1001, 4'b0000, own, d, a, dn);
      checks++;
      if (own !== 4'b0001 || d !== 8'hFF || dn !== 4'b0001) begin
         errors++;
         $display("FAIL midreset_restart: owner=%b din=%h done=%b required 0001 ff 0001", own, d, dn);
      end
   endtask

   initial begin
      clk      = 1'b0;
      rst      = 1'b1;
      req      = 4'b0000;
      req_data = 32'd0;
      tx_busy  = 1'b0;
      tx_done  = 1'b0;
      checks   = 0;
      errors   = 0;
      test_reset();
      test_single();
      test_round_robin();
      test_late_arrival();
      test_timeout();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
